// File: rtl/markov_pkg.sv
// Shared types and default sizing for the Markov training sequencer.
package markov_pkg;

    localparam int unsigned SYM_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSym,
        StScan,
        StInc,
        StAdd,
        StFinish
    } state_e;

    typedef struct packed {
        logic [SYM_W_DEF-1:0] from_sym;
        logic [SYM_W_DEF-1:0] to_sym;
        logic [CNT_W_DEF-1:0] cnt;
    } entry_t;

endpackage

// File: rtl/markov_table.sv
// Transition-list storage: one write port, a scan read port and an external read port.
module markov_table
    import markov_pkg::*;
#(
    parameter int unsigned SYM_W = SYM_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SYM_W-1:0]         wfrom,
    input  logic [SYM_W-1:0]         wto,
    input  logic [CNT_W-1:0]         wcnt,
    input  logic [$clog2(DEPTH)-1:0] scan_idx,
    output logic [SYM_W-1:0]         scan_from,
    output logic [SYM_W-1:0]         scan_to,
    output logic [CNT_W-1:0]         scan_cnt,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [SYM_W-1:0]         rd_from,
    output logic [SYM_W-1:0]         rd_to,
    output logic [CNT_W-1:0]         rd_cnt
);

    logic [SYM_W-1:0] from_mem [DEPTH];
    logic [SYM_W-1:0] to_mem   [DEPTH];
    logic [CNT_W-1:0] cnt_mem  [DEPTH];

    // No reset: entries beyond the valid count are never interpreted.
    always_ff @(posedge clk) begin
        if (we) begin
            from_mem[waddr] <= wfrom;
            to_mem[waddr]   <= wto;
            cnt_mem[waddr]  <= wcnt;
        end
    end

    assign scan_from = from_mem[scan_idx];
    assign scan_to   = to_mem[scan_idx];
    assign scan_cnt  = cnt_mem[scan_idx];

    assign rd_from = from_mem[rd_idx];
    assign rd_to   = to_mem[rd_idx];
    assign rd_cnt  = cnt_mem[rd_idx];

endmodule

// File: rtl/markov_train_ctrl.sv
// Training sequencer: pairs consecutive symbols, scans the list, then counts or appends.
module markov_train_ctrl
    import markov_pkg::*;
#(
    parameter int unsigned SYM_W = SYM_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_data,
    input  logic                     sym_last,
    output logic                     sym_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   entries,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [SYM_W-1:0]         rd_from,
    output logic [SYM_W-1:0]         rd_to,
    output logic [CNT_W-1:0]         rd_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned EW = IW + 1;
    localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);

    state_e           state_q;
    logic [EW-1:0]    i_q;
    logic [EW-1:0]    entries_q;
    logic [SYM_W-1:0] prev_q;
    logic [SYM_W-1:0] cur_q;
    logic             last_q;
    logic             prev_valid_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    logic [SYM_W-1:0] scan_from;
    logic [SYM_W-1:0] scan_to;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_hit;
    logic [CNT_W-1:0] cnt_next;

    logic             we;
    logic [IW-1:0]    waddr;
    logic [CNT_W-1:0] wcnt;

    assign scan_hit = (i_q < entries_q) && (scan_from == prev_q) && (scan_to == cur_q);
    assign cnt_next = (scan_cnt == {CNT_W{1'b1}}) ? scan_cnt : scan_cnt + 1'b1;

    always_comb begin
        we    = 1'b0;
        waddr = entries_q[IW-1:0];
        wcnt  = CNT_W'(1);
        if (state_q == StInc) begin
            we    = 1'b1;
            waddr = i_q[IW-1:0];
            wcnt  = cnt_next;
        end else if (state_q == StAdd && entries_q < DEPTH_E) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            i_q          <= '0;
            entries_q    <= '0;
            prev_q       <= '0;
            cur_q        <= '0;
            last_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFinish: begin
                    if (start) begin
                        state_q      <= StWaitSym;
                        entries_q    <= '0;
                        overflow_q   <= 1'b0;
                        done_q       <= 1'b0;
                        prev_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        ready_q      <= 1'b1;
                    end
                end
                StWaitSym: begin
                    if (sym_valid) begin
                        cur_q  <= sym_data;
                        last_q <= sym_last;
                        if (!prev_valid_q) begin
                            prev_q       <= sym_data;
                            prev_valid_q <= 1'b1;
                            if (sym_last) begin
                                state_q <= StFinish;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            i_q     <= '0;
                            state_q <= StScan;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StScan: begin
                    if (i_q == entries_q) begin
                        state_q <= StAdd;
                    end else if (scan_hit) begin
                        state_q <= StInc;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                StInc, StAdd: begin
                    if (state_q == StAdd) begin
                        if (entries_q < DEPTH_E) begin
                            entries_q <= entries_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    prev_q <= cur_q;
                    if (last_q) begin
                        state_q <= StFinish;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StWaitSym;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    markov_table #(
        .SYM_W(SYM_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_table (
        .clk      (clk),
        .we       (we),
        .waddr    (waddr),
        .wfrom    (prev_q),
        .wto      (cur_q),
        .wcnt     (wcnt),
        .scan_idx (i_q[IW-1:0]),
        .scan_from(scan_from),
        .scan_to  (scan_to),
        .scan_cnt (scan_cnt),
        .rd_idx   (rd_idx),
        .rd_from  (rd_from),
        .rd_to    (rd_to),
        .rd_cnt   (rd_cnt)
    );

    assign sym_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign entries   = entries_q;

endmodule

// File: tb/tb_markov_train_ctrl.sv
// Bench for markov_train_ctrl at DEPTH=4, CNT_W=2: directed vector table plus random streams.
module tb_markov_train_ctrl;

    localparam int unsigned SYM_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             sym_valid = 1'b0;
    logic [SYM_W-1:0] sym_data = '0;
    logic             sym_last = 1'b0;
    logic             sym_ready;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [2:0]       entries;
    logic [1:0]       rd_idx = '0;
    logic [SYM_W-1:0] rd_from;
    logic [SYM_W-1:0] rd_to;
    logic [CNT_W-1:0] rd_cnt;

    always #5 clk = ~clk;

    markov_train_ctrl #(
        .SYM_W(SYM_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sym_valid(sym_valid),
        .sym_data (sym_data),
        .sym_last (sym_last),
        .sym_ready(sym_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .entries  (entries),
        .rd_idx   (rd_idx),
        .rd_from  (rd_from),
        .rd_to    (rd_to),
        .rd_cnt   (rd_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit noise   = 1'b0;

    // Reference model: the transition list as plain queues.
    logic [7:0] mf[$];
    logic [7:0] mt[$];
    int         mc[$];
    logic [7:0] mprev;
    bit         mpv;
    bit         movf;
    int         m_gap;

    typedef struct {
        bit         st;
        logic [7:0] sym;
        bit         last;
        int         gap;
        int         ent;
        bit         ovf;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_start();
        mf.delete();
        mt.delete();
        mc.delete();
        mpv  = 1'b0;
        movf = 1'b0;
    endtask

    task automatic model_sym(input logic [7:0] d);
        int idx;
        if (!mpv) begin
            mprev = d;
            mpv   = 1'b1;
            m_gap = 0;
        end else begin
            idx = -1;
            foreach (mf[k]) if (idx < 0 && mf[k] == mprev && mt[k] == d) idx = k;
            if (idx >= 0) begin
                mc[idx] = (mc[idx] >= CMAX) ? CMAX : mc[idx] + 1;
                m_gap   = idx + 2;
            end else begin
                m_gap = mf.size() + 2;
                if (mf.size() < DEPTH) begin
                    mf.push_back(mprev);
                    mt.push_back(d);
                    mc.push_back(1);
                end else begin
                    movf = 1'b1;
                end
            end
            mprev = d;
        end
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_start();
        check("start_busy", int'(busy), 1);
        check("start_done", int'(done), 0);
        check("start_ready", int'(sym_ready), 1);
        check("start_entries", int'(entries), 0);
    endtask

    // Offers one symbol, then counts cycles from the handshake until the DUT is ready again.
    task automatic do_sym(input logic [7:0] d, input bit l, output int gap);
        int w = 0;
        model_sym(d);
        sym_valid = 1'b1;
        sym_data  = d;
        sym_last  = l;
        while (sym_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (sym_ready !== 1'b1) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (l) sym_valid = 1'b0;
        gap = 0;
        while (!(l ? done === 1'b1 : sym_ready === 1'b1) && gap < 100) begin
            start = noise && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            gap++;
        end
        start = 1'b0;
    endtask

    task automatic end_run();
        repeat (3) @(posedge clk);
        #1;
        check("end_done", int'(done), 1);
        check("end_busy", int'(busy), 0);
        check("end_ready", int'(sym_ready), 0);
        check("end_entries", int'(entries), mf.size());
        check("end_overflow", int'(overflow), int'(movf));
        for (int k = 0; k < mf.size(); k++) begin
            rd_idx = 2'(k);
            #1;
            check($sformatf("tbl_from[%0d]", k), int'(rd_from), int'(mf[k]));
            check($sformatf("tbl_to[%0d]", k), int'(rd_to), int'(mt[k]));
            check($sformatf("tbl_cnt[%0d]", k), int'(rd_cnt), mc[k]);
        end
    endtask

    initial begin
        int g;

        // st, sym, last, gap, entries, overflow
        vecs.push_back('{1, 8'h41, 0, 0, 0, 0});
        vecs.push_back('{0, 8'h42, 0, 2, 1, 0});
        vecs.push_back('{0, 8'h41, 0, 3, 2, 0});
        vecs.push_back('{0, 8'h42, 1, 2, 2, 0});
        vecs.push_back('{1, 8'h43, 1, 0, 0, 0});
        vecs.push_back('{1, 8'h01, 0, 0, 0, 0});
        vecs.push_back('{0, 8'h02, 0, 2, 1, 0});
        vecs.push_back('{0, 8'h03, 0, 3, 2, 0});
        vecs.push_back('{0, 8'h04, 0, 4, 3, 0});
        vecs.push_back('{0, 8'h05, 0, 5, 4, 0});
        vecs.push_back('{0, 8'h06, 1, 6, 4, 1});
        vecs.push_back('{1, 8'h07, 0, 0, 0, 0});
        for (int k = 0; k < 4; k++) vecs.push_back('{0, 8'h07, 0, 2, 1, 0});
        vecs.push_back('{0, 8'h07, 1, 2, 1, 0});
        vecs.push_back('{1, 8'h01, 0, 0, 0, 0});
        vecs.push_back('{0, 8'h02, 0, 2, 1, 0});
        vecs.push_back('{0, 8'h03, 0, 3, 2, 0});
        vecs.push_back('{0, 8'h01, 0, 4, 3, 0});
        vecs.push_back('{0, 8'h02, 0, 2, 3, 0});
        vecs.push_back('{0, 8'h03, 0, 3, 3, 0});
        vecs.push_back('{0, 8'h01, 1, 4, 3, 0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(sym_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_entries", int'(entries), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_done", int'(done), 0);

        foreach (vecs[r]) begin
            if (vecs[r].st) begin_run();
            do_sym(vecs[r].sym, vecs[r].last, g);
            check($sformatf("vec%0d_gap", r), g, vecs[r].gap);
            check($sformatf("vec%0d_entries", r), int'(entries), vecs[r].ent);
            check($sformatf("vec%0d_overflow", r), int'(overflow), int'(vecs[r].ovf));
            if (vecs[r].last) end_run();
        end

        // Reset asserted while scanning a non-empty list.
        begin_run();
        do_sym(8'h05, 0, g);
        do_sym(8'h06, 0, g);
        sym_valid = 1'b1;
        sym_data  = 8'h07;
        sym_last  = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_ready", int'(sym_ready), 0);
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_entries", int'(entries), 1);
        reset = 1'b0;
        sym_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(sym_ready), 0);
        check("midrst_entries", int'(entries), 0);
        check("midrst_done", int'(done), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Random streams over a small alphabet, with stray start pulses mid-run.
        noise = 1'b1;
        for (int run = 0; run < 25; run++) begin
            int len;
            len = $urandom_range(1, 12);
            begin_run();
            for (int s = 0; s < len; s++) begin
                logic [7:0] d;
                bit         l;
                d = 8'h10 + 8'($urandom_range(0, 2));
                l = (s == len - 1);
                do_sym(d, l, g);
                check($sformatf("rnd%0d_%0d_gap", run, s), g, m_gap);
                check($sformatf("rnd%0d_%0d_entries", run, s), int'(entries), mf.size());
                check($sformatf("rnd%0d_%0d_overflow", run, s), int'(overflow), int'(movf));
            end
            end_run();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
